// File: rtl/spectrum_histogram_streamer_pkg.sv
// Shared constants and state encoding for the histogram streamer and the
// downstream bin-ratio ensemble, so both sides agree on bin count and widths.
package spectrum_histogram_streamer_pkg;

    localparam int NUM_BINS = 1024;
    localparam int CH_W     = 10;
    localparam int CNT_W    = 20;
    localparam int DROP_W   = 16;
    localparam int ACQ_W    = 20;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACQ,
        ST_DRAIN,
        ST_WAIT,
        ST_STREAM
    } state_t;

endpackage

// File: rtl/spectrum_histogram_streamer_hist_ram.sv
// NUM_BINS x CNT_W simple dual-port histogram store with a registered read port.
// A read and a write to the same address in one cycle returns the old contents.
module hist_ram_1r1w #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and read register have no reset; a reset would block
    // block-RAM inference, and the CLEAR state zeroes the contents instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spectrum_histogram_streamer.sv
// Accumulates detector events into a saturating histogram, then streams and
// clears the bins one per cycle once the ensemble reports itself idle.
module spectrum_histogram_streamer #(
    parameter int NUM_BINS = spectrum_histogram_streamer_pkg::NUM_BINS,
    parameter int CH_W     = spectrum_histogram_streamer_pkg::CH_W,
    parameter int CNT_W    = spectrum_histogram_streamer_pkg::CNT_W,
    parameter int DROP_W   = spectrum_histogram_streamer_pkg::DROP_W
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        acq_start,
    input  logic [spectrum_histogram_streamer_pkg::ACQ_W-1:0] acq_events,
    input  logic                                        event_valid,
    input  logic [CH_W-1:0]                             event_channel,
    input  logic                                        request_over_ensemble,
    output logic                                        trans_start,
    output logic [CNT_W-1:0]                            bin_cnt,
    output logic                                        busy,
    output logic [DROP_W-1:0]                           drop_cnt
);

    import spectrum_histogram_streamer_pkg::*;

    localparam int IDX_W = CH_W + 1;
    localparam logic [IDX_W-1:0]  LAST_BIN   = IDX_W'(NUM_BINS - 1);
    localparam logic [IDX_W-1:0]  STREAM_END = IDX_W'(NUM_BINS);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [DROP_W-1:0] DROP_MAX   = '1;

    state_t state_q, state_d;

    // Shared cycle counter: bin pointer in CLEAR/STREAM, cycle count in DRAIN.
    logic [IDX_W-1:0] idx_q;
    logic [CH_W-1:0]  next_bin;

    logic [ACQ_W-1:0] target_q;
    logic [ACQ_W-1:0] accepted_q;
    logic             accept;
    logic             reach_target;

    // Read-modify-write pipeline: stage 1 holds the outstanding read,
    // stage 2 remembers the last write for same-channel forwarding.
    logic             s1_valid_q;
    logic [CH_W-1:0]  s1_ch_q;
    logic             s2_valid_q;
    logic [CH_W-1:0]  s2_ch_q;
    logic [CNT_W-1:0] s2_data_q;
    logic [CNT_W-1:0] s2_old;
    logic [CNT_W-1:0] s2_new;

    logic             rd_en;
    logic [CH_W-1:0]  rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             wr_en;
    logic [CH_W-1:0]  wr_addr;
    logic [CNT_W-1:0] wr_data;

    hist_ram_1r1w #(
        .DEPTH  (NUM_BINS),
        .ADDR_W (CH_W),
        .DATA_W (CNT_W)
    ) u_hist_ram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    assign next_bin     = idx_q[CH_W-1:0] + CH_W'(1);
    assign accept       = (state_q == ST_ACQ) && event_valid;
    assign reach_target = accept && ((accepted_q + ACQ_W'(1)) == target_q);
    assign s2_old       = (s2_valid_q && (s2_ch_q == s1_ch_q)) ? s2_data_q : rd_data;
    assign s2_new       = (s2_old == CNT_MAX) ? s2_old : s2_old + CNT_W'(1);
    assign trans_start  = (state_q == ST_STREAM) && (idx_q == '0);
    assign busy         = (state_q != ST_IDLE);

    // NOTE: the state register uses non-blocking assignment so every
    // sequential process samples the pre-edge value of state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = idx_q[CH_W-1:0];
                if (idx_q == LAST_BIN) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (acq_start) begin
                    state_d = (acq_events == '0) ? ST_DRAIN : ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (event_valid) begin
                    rd_en   = 1'b1;
                    rd_addr = event_channel;
                end
                if (reach_target) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (idx_q == IDX_W'(1)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Fetch bin 0 early so bin_cnt can be a plain register.
                if (request_over_ensemble) begin
                    rd_en   = 1'b1;
                    wr_en   = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (idx_q < LAST_BIN) begin
                    rd_en   = 1'b1;
                    rd_addr = next_bin;
                    wr_en   = 1'b1;
                    wr_addr = next_bin;
                end
                if (idx_q == STREAM_END) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        if (s1_valid_q) begin
            wr_en   = 1'b1;
            wr_addr = s1_ch_q;
            wr_data = s2_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            target_q   <= '0;
            accepted_q <= '0;
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_ch_q    <= '0;
            s2_data_q  <= '0;
            bin_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            idx_q <= (state_d != state_q) ? '0 : idx_q + IDX_W'(1);

            if ((state_q == ST_IDLE) && acq_start) begin
                target_q   <= acq_events;
                accepted_q <= '0;
            end else if (accept) begin
                accepted_q <= accepted_q + ACQ_W'(1);
            end

            s1_valid_q <= accept;
            s1_ch_q    <= event_channel;
            s2_valid_q <= s1_valid_q;
            s2_ch_q    <= s1_ch_q;
            s2_data_q  <= s2_new;

            bin_cnt <= ((state_q == ST_STREAM) && (idx_q < STREAM_END)) ? rd_data : '0;

            if (event_valid && !accept && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spectrum_histogram_streamer.sv
// Self-checking bench: table-driven acquisitions, hand-written corner cases and
// randomized acquisitions checked against a bin-array reference model.
module tb_spectrum_histogram_streamer;

    localparam int NB       = 1024;
    localparam int CHW      = 10;
    localparam int CW       = 12;
    localparam int DW       = 6;
    localparam int AW       = 20;
    localparam int CNT_MAX  = (1 << CW) - 1;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          acq_start;
    logic [AW-1:0] acq_events;
    logic          event_valid;
    logic [CHW-1:0] event_channel;
    logic          request_over_ensemble;
    logic          trans_start;
    logic [CW-1:0] bin_cnt;
    logic          busy;
    logic [DW-1:0] drop_cnt;

    spectrum_histogram_streamer #(
        .NUM_BINS (NB),
        .CH_W     (CHW),
        .CNT_W    (CW),
        .DROP_W   (DW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .acq_start             (acq_start),
        .acq_events            (acq_events),
        .event_valid           (event_valid),
        .event_channel         (event_channel),
        .request_over_ensemble (request_over_ensemble),
        .trans_start           (trans_start),
        .bin_cnt               (bin_cnt),
        .busy                  (busy),
        .drop_cnt              (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int c0, c1, c2, c3, c4;
        int bin_a, val_a;
        int bin_b, val_b;
    } vec_t;

    vec_t vecs [7];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   model_bins [NB];
    int   exp_bins [NB];
    int   model_drop = 0;
    int   ev_q [$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_event(input int ch);
        if (model_bins[ch] < CNT_MAX) model_bins[ch] = model_bins[ch] + 1;
    endtask

    task automatic model_dropped;
        if (model_drop < DROP_MAX) model_drop = model_drop + 1;
    endtask

    task automatic noise(input int pct);
        event_valid   = ($urandom_range(99) < pct);
        event_channel = CHW'($urandom_range(NB - 1));
        if (event_valid) model_dropped();
    endtask

    task automatic clear_model;
        for (int i = 0; i < NB; i++) model_bins[i] = 0;
    endtask

    task automatic clear_len_check(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            n++;
            tick();
        end
        check({tag, " clear_len"}, n, NB);
    endtask

    // Full acquisition from IDLE back to IDLE; channels come from ev_q.
    task automatic run_acq(input string tag, input int n, input int gap_pct,
                           input int wait_noise, input int req_delay,
                           input int stream_noise, input bit stream_acq,
                           input bit use_model);
        int i = 0;
        int ts = 0;
        int mism = 0;
        int first_k = -1;
        int first_v = 0;
        int not_busy = 0;
        check({tag, " idle_before"}, int'(busy), 0);
        acq_events = AW'(n);
        acq_start  = 1'b1;
        tick();
        acq_start = 1'b0;
        while (i < n) begin
            if ($urandom_range(99) < gap_pct) begin
                event_valid = 1'b0;
                acq_start   = ($urandom_range(3) == 0);
                acq_events  = AW'($urandom_range(1, 3));
            end else begin
                event_valid   = 1'b1;
                event_channel = CHW'(ev_q[i]);
                model_event(ev_q[i]);
                i++;
            end
            tick();
            acq_start = 1'b0;
        end
        event_valid = 1'b0;
        check({tag, " drain1_busy"}, int'(busy), 1);
        tick();
        check({tag, " drain2_busy"}, int'(busy), 1);
        check({tag, " drain2_no_ts"}, int'(trans_start), 0);
        request_over_ensemble = (req_delay == 0);
        tick();
        check({tag, " wait_busy"}, int'(busy), 1);
        check({tag, " wait_no_ts"}, int'(trans_start), 0);
        for (int j = 0; j < req_delay; j++) begin
            noise(wait_noise);
            tick();
            ts += int'(trans_start);
        end
        if (req_delay > 0) check({tag, " wait_hold_ts"}, ts, 0);
        noise(wait_noise);
        request_over_ensemble = 1'b1;
        tick();
        check({tag, " trans_start"}, int'(trans_start), 1);
        check({tag, " bin_cnt_at_start"}, int'(bin_cnt), 0);
        request_over_ensemble = 1'b0;
        if (use_model) exp_bins = model_bins;
        ts = 0;
        for (int k = 0; k < NB; k++) begin
            noise(stream_noise);
            acq_start  = stream_acq && (k == 100);
            acq_events = AW'(7);
            tick();
            if (int'(bin_cnt) != exp_bins[k]) begin
                if (first_k < 0) begin
                    first_k = k;
                    first_v = int'(bin_cnt);
                end
                mism++;
            end
            ts += int'(trans_start);
            not_busy += int'(!busy);
        end
        event_valid = 1'b0;
        acq_start   = 1'b0;
        check($sformatf("%s stream_bins (first bad bin %0d read %0d)", tag, first_k, first_v), mism, 0);
        check({tag, " stream_single_ts"}, ts, 0);
        check({tag, " stream_busy"}, not_busy, 0);
        tick();
        check({tag, " idle_after"}, int'(busy), 0);
        check({tag, " bin_cnt_idle"}, int'(bin_cnt), 0);
        if (stream_acq) begin
            tick();
            check({tag, " acq_start_ignored"}, int'(busy), 0);
        end
        check({tag, " drop_cnt"}, int'(drop_cnt), model_drop);
        clear_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs [5];
        rst_n = 1'b0;
        acq_start = 1'b0;
        acq_events = '0;
        event_valid = 1'b0;
        event_channel = '0;
        request_over_ensemble = 1'b0;
        clear_model();

        vecs[0] = '{0, 0, 0, 0, 0, 0, -1, 0, -1, 0};
        vecs[1] = '{5, 3, 3, 3, 7, 3, 3, 4, 7, 1};
        vecs[2] = '{2, 9, 9, 0, 0, 0, 9, 2, -1, 0};
        vecs[3] = '{1, 9, 0, 0, 0, 0, 9, 1, -1, 0};
        vecs[4] = '{4, 5, 6, 5, 5, 0, 5, 3, 6, 1};
        vecs[5] = '{3, 1023, 0, 1023, 0, 0, 1023, 2, 0, 1};
        vecs[6] = '{5, 12, 12, 12, 12, 12, 12, 5, -1, 0};

        #1;
        check("reset busy", int'(busy), 1);
        check("reset trans_start", int'(trans_start), 0);
        check("reset bin_cnt", int'(bin_cnt), 0);
        check("reset drop_cnt", int'(drop_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_len_check("por");

        // Table-driven acquisitions, request already high on WAIT entry.
        for (int v = 0; v < 7; v++) begin
            cs = '{vecs[v].c0, vecs[v].c1, vecs[v].c2, vecs[v].c3, vecs[v].c4};
            ev_q.delete();
            for (int i = 0; i < vecs[v].n; i++) ev_q.push_back(cs[i]);
            for (int i = 0; i < NB; i++) exp_bins[i] = 0;
            if (vecs[v].bin_a >= 0) exp_bins[vecs[v].bin_a] = vecs[v].val_a;
            if (vecs[v].bin_b >= 0) exp_bins[vecs[v].bin_b] = vecs[v].val_b;
            run_acq($sformatf("vec%0d", v), vecs[v].n, 0, 0, 0, 0, 1'b0, 1'b0);
        end

        // Saturation: more events than the counter can hold, all on bin 0.
        ev_q.delete();
        for (int i = 0; i < CNT_MAX + 5; i++) ev_q.push_back(0);
        for (int i = 0; i < NB; i++) exp_bins[i] = 0;
        exp_bins[0] = CNT_MAX;
        run_acq("saturate", CNT_MAX + 5, 0, 0, 0, 0, 1'b0, 1'b0);

        // Request held low for 50 WAIT cycles.
        ev_q = {42};
        run_acq("hold_low", 1, 0, 0, 50, 0, 1'b0, 1'b1);

        // Exactly three events during WAIT, acq_start during STREAM.
        ev_q = {11};
        run_acq("drop3", 1, 0, 100, 2, 0, 1'b1, 1'b1);
        check("drop3 literal", int'(drop_cnt), 3);

        // Randomized acquisitions against the reference model.
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 60);
            int base = $urandom_range(NB - 4);
            ev_q.delete();
            for (int i = 0; i < n; i++)
                ev_q.push_back(($urandom_range(3) == 0) ? $urandom_range(NB - 1) : base + $urandom_range(2));
            run_acq($sformatf("rand%0d", r), n, 30, 40, $urandom_range(0, 8), 10, 1'(r % 2), 1'b1);
        end

        // Drop counter saturation from IDLE.
        for (int i = 0; i < DROP_MAX + 7; i++) begin
            event_valid   = 1'b1;
            event_channel = CHW'(i);
            model_dropped();
            tick();
        end
        event_valid = 1'b0;
        tick();
        check("drop_saturate", int'(drop_cnt), DROP_MAX);
        check("drop_saturate model", int'(drop_cnt), model_drop);

        // Reset mid-STREAM discards the partial spectrum.
        ev_q = {4, 4, 600};
        acq_events = AW'(3);
        acq_start  = 1'b1;
        tick();
        acq_start = 1'b0;
        foreach (ev_q[i]) begin
            event_valid   = 1'b1;
            event_channel = CHW'(ev_q[i]);
            tick();
        end
        event_valid = 1'b0;
        request_over_ensemble = 1'b1;
        tick();
        tick();
        tick();
        check("abort trans_start", int'(trans_start), 1);
        request_over_ensemble = 1'b0;
        repeat (5) tick();
        check("abort bin4_before_reset", int'(bin_cnt), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort bin_cnt", int'(bin_cnt), 0);
        check("abort busy", int'(busy), 1);
        check("abort trans_start_low", int'(trans_start), 0);
        check("abort drop_cnt", int'(drop_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        model_drop = 0;
        clear_model();
        clear_len_check("post_abort");
        ev_q.delete();
        run_acq("post_abort_empty", 0, 0, 0, 3, 0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spectrum_histogram_streamer.md
# spectrum_histogram_streamer

Upstream feeder for the bin-ratio ensemble spiking network. It accumulates detector events into an on-chip histogram of `NUM_BINS` saturating counters. When the acquisition target is reached and the ensemble reports itself idle, it pulses `trans_start` and streams the bins one per cycle on `bin_cnt`. Bins are cleared as they are read, so the next acquisition starts from an empty histogram without a separate clear pass.

## Interface
- `NUM_BINS`, 1024: number of histogram bins (power of two).
- `CH_W`, 10: event channel width, equal to log2(`NUM_BINS`).
- `CNT_W`, 20: bin counter width; must equal the ensemble `bin_cnt` width.
- `DROP_W`, 16: dropped-event counter width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `acq_start` input 1: one-cycle command to begin an acquisition; honoured only in IDLE.
- `acq_events` input 20: number of events to accept; sampled on an honoured `acq_start`.
- `event_valid` input 1: one detector event this cycle.
- `event_channel` input `CH_W`: energy bin of the event.
- `request_over_ensemble` input 1: high means the ensemble is idle and may take a spectrum.
- `trans_start` output 1: one-cycle pulse that precedes the stream.
- `bin_cnt` output `CNT_W`: streamed bin value.
- `busy` output 1: high in every state except IDLE.
- `drop_cnt` output `DROP_W`: saturating count of events that were not accepted.

## Operation
- State CLEAR: entered after reset. Writes zero to bin 0..`NUM_BINS`-1, one bin per cycle, then goes to IDLE.
- State IDLE: waits for `acq_start`.
  - Latches `acq_events` and zeroes the accepted-event counter.
  - Goes to ACQ, or to DRAIN if `acq_events`==0.
- State ACQ: each `event_valid` is an accepted event.
  - Performs a 2-stage read-modify-write: read in stage 1, increment and write in stage 2.
  - The increment saturates at 2^`CNT_W`-1. A saturated bin holds and the event still counts toward the target.
  - Same-channel events on consecutive cycles are forwarded from stage 2, so no increment is lost.
  - When the accepted count reaches the target, go to DRAIN. The event that reaches the target is accepted.
- State DRAIN: 2 cycles to retire the pipeline, then go to WAIT.
- State WAIT: holds until `request_over_ensemble`==1, then goes to STREAM.
- State STREAM: on cycle 0, `trans_start`=1. On cycles 1..`NUM_BINS`, `bin_cnt` = bin k on cycle k+1.
  - Each bin is written to zero in the same access that reads it.
  - After bin `NUM_BINS`-1 is presented, go to IDLE.
- Events:
  - Any `event_valid` outside ACQ increments `drop_cnt`, which saturates at 2^`DROP_W`-1.
  - `drop_cnt` is cleared only by reset.
- `acq_start` outside IDLE is ignored and has no side effect.

## Timing
- Reset values:
  - `trans_start`=0, `bin_cnt`=0, `drop_cnt`=0.
  - `busy`=1 because reset enters CLEAR.
  - FSM=CLEAR, histogram contents undefined until CLEAR completes.
- CLEAR lasts exactly `NUM_BINS` cycles. `busy` falls on the cycle after the last write.
- An honoured `acq_start` at cycle t gives ACQ at t+1. `event_valid` is accepted starting at t+1.
- A target reached at cycle t gives DRAIN t+1..t+2 and WAIT at t+3. STREAM starts the cycle after `request_over_ensemble` is sampled high in WAIT.
- `bin_cnt` is registered. It holds 0 outside STREAM data cycles and holds the last value only during those cycles.
- Total stream length is `NUM_BINS`+1 cycles, and `request_over_ensemble` is not rechecked during the stream.
- If `request_over_ensemble` is already high on entry to WAIT, WAIT lasts exactly 1 cycle.
- Reset asserted mid-ACQ or mid-STREAM aborts immediately. After release the block re-enters CLEAR, and the partial spectrum is discarded.

## Structure
- The shared package holds:
  - the state enum (CLEAR, IDLE, ACQ, DRAIN, WAIT, STREAM);
  - `NUM_BINS`, `CNT_W`, `CH_W`, so the ensemble and this block agree.
- One sub-module, `hist_ram_1r1w`: a `NUM_BINS`x`CNT_W` simple dual-port RAM with synchronous read.
  - Reads and writes to different addresses in the same cycle.
  - Infers block RAM.

## Test plan
- Reset release: `busy`=1 for 1024 cycles, then 0. A stream with `acq_events`=0 yields 1024 zeros.
- `acq_events`=5, events on channels 3,3,3,7,3 back-to-back: stream shows bin3=4, bin7=1, all others 0, and `busy` stays 1 through DRAIN.
- 2^20+3 events all on channel 0: bin0=1048575 (saturated). Entry to WAIT follows the final event, unaffected by saturation.
- `request_over_ensemble` held low for 50 cycles in WAIT: `trans_start` stays 0, then pulses exactly one cycle after the request rises. Bin 0 appears on the next cycle.
- Two acquisitions back-to-back, channel 9 ×2 then channel 9 ×1: the second stream shows bin9=1, proving clear-on-read.
- Three events during WAIT plus an `acq_start` during STREAM: `drop_cnt`=3, the `acq_start` is ignored, and the FSM returns to IDLE. Reset mid-STREAM re-enters CLEAR with `bin_cnt`=0.
